// File: rtl/riscv_boot_pkg.sv
// riscv_boot_pkg: shared types and constants for the boot sequencer.
//   state_t             - sequencer FSM states
//   TOHOST_ADDR_DEFAULT - byte address whose store ends a run
//   PASS_CODE           - tohost value that means the program passed
package riscv_boot_pkg;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;
    localparam int unsigned PASS_CODE           = 1;

endpackage

// File: rtl/boot_load_ptr.sv
// boot_load_ptr: per-channel load write pointer with an exhaustion flag.
//   gclk  - clock
//   clear - synchronous clear of pointer and full flag (highest priority)
//   inc   - advance the pointer; ignored once full
//   ptr   - word address of the next write
//   full  - set after the write at address 2^ADDR_W-1
module boot_load_ptr #(
    parameter int ADDR_W = 10
) (
    input  logic              gclk,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr,
    output logic              full
);

    logic [ADDR_W-1:0] ptr_d, ptr_q;
    logic              full_d, full_q;

    always_comb begin
        ptr_d  = ptr_q;
        full_d = full_q;
        if (inc && !full_q) begin
            // pointer wraps to 0 but the full flag blocks any further writes
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == '1) full_d = 1'b1;
        end
    end

    always_ff @(posedge gclk) begin
        if (clear) begin
            ptr_q  <= '0;
            full_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            full_q <= full_d;
        end
    end

    assign ptr  = ptr_q;
    assign full = full_q;

endmodule

// File: rtl/riscv_boot_sequencer.sv
// riscv_boot_sequencer: load-and-run controller for the RISC-V core.
//   Load port  : LOAD_VALID/LOAD_READY/LOAD_DATA/LOAD_SEL/LOAD_LAST stream
//                image words into NUM_MEM channels.
//   Memory side: MEM_WE (one-hot), MEM_ADDR, MEM_WDATA, registered one cycle
//                after the accepted beat.
//   Core side  : CORE_RESET_N held low during load and for RST_HOLD cycles
//                after the last write; RAM_ADDRESS/RAM_DATAIN/RAM_WE watched
//                for the tohost store.
//   Status     : CYCLE_COUNT, DONE, PASS, TIMED_OUT, LOAD_ERR, RESULT.
module riscv_boot_sequencer
    import riscv_boot_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 10,
    parameter int          NUM_MEM     = 2,
    parameter int          SEL_W       = (NUM_MEM > 1 ? $clog2(NUM_MEM) : 1),
    parameter int          RST_HOLD    = 4,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               LOAD_VALID,
    output logic               LOAD_READY,
    input  logic [DATA_W-1:0]  LOAD_DATA,
    input  logic [SEL_W-1:0]   LOAD_SEL,
    input  logic               LOAD_LAST,
    output logic [NUM_MEM-1:0] MEM_WE,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [DATA_W-1:0]  MEM_WDATA,
    output logic               CORE_RESET_N,
    input  logic [31:0]        RAM_ADDRESS,
    input  logic [DATA_W-1:0]  RAM_DATAIN,
    input  logic               RAM_WE,
    input  logic [CNT_W-1:0]   TIMEOUT_LIMIT,
    output logic [CNT_W-1:0]   CYCLE_COUNT,
    output logic               DONE,
    output logic               PASS,
    output logic               TIMED_OUT,
    output logic               LOAD_ERR,
    output logic [DATA_W-1:0]  RESULT
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t state_d, state_q;

    logic [NUM_MEM-1:0][ADDR_W-1:0] ch_ptr;
    logic [NUM_MEM-1:0]             ch_full;
    logic [NUM_MEM-1:0]             sel_hit, ptr_inc;
    logic                           sel_ok, sel_full;
    logic [ADDR_W-1:0]              sel_ptr;
    logic                           accept, do_write, tohost_hit, timeout_hit;

    logic [NUM_MEM-1:0] mem_we_d, mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_d, mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_d, mem_wdata_q;
    logic [HOLD_W-1:0]  hold_cnt_d, hold_cnt_q;
    logic [CNT_W-1:0]   cycle_cnt_d, cycle_cnt_q;
    logic               done_d, done_q;
    logic               pass_d, pass_q;
    logic               timed_out_d, timed_out_q;
    logic               load_err_d, load_err_q;
    logic [DATA_W-1:0]  result_d, result_q;

    // ---- per-channel pointers ----
    for (genvar g = 0; g < NUM_MEM; g++) begin : g_ptr
        boot_load_ptr #(.ADDR_W(ADDR_W)) u_ptr (
            .gclk  (CLK),
            .clear (RESET),
            .inc   (ptr_inc[g]),
            .ptr   (ch_ptr[g]),
            .full  (ch_full[g])
        );
    end

    // Decode the select by matching each legal channel; any select value
    // that matches none is out of range and gets dropped.
    always_comb begin
        sel_hit  = '0;
        sel_ok   = 1'b0;
        sel_full = 1'b0;
        sel_ptr  = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (LOAD_SEL == SEL_W'(i)) begin
                sel_hit[i] = 1'b1;
                sel_ok     = 1'b1;
                sel_full   = ch_full[i];
                sel_ptr    = ch_ptr[i];
            end
        end
    end

    assign accept      = LOAD_VALID && LOAD_READY;
    assign do_write    = accept && sel_ok && !sel_full;
    assign ptr_inc     = do_write ? sel_hit : '0;
    assign tohost_hit  = (state_q == S_RUN) && RAM_WE && (RAM_ADDRESS == TOHOST_ADDR);
    assign timeout_hit = (state_q == S_RUN) && (TIMEOUT_LIMIT != '0) &&
                         (cycle_cnt_q == TIMEOUT_LIMIT - CNT_W'(1));

    // ---- FSM: state register ----
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_LOAD;
        else       state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD: if (accept && LOAD_LAST)        state_d = S_HOLD;
            S_HOLD: if (hold_cnt_q == '0)           state_d = S_RUN;
            S_RUN:  if (tohost_hit || timeout_hit)  state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            default: state_d = S_LOAD;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        LOAD_READY   = (state_q == S_LOAD);
        CORE_RESET_N = (state_q == S_RUN);
    end

    // ---- datapath next values ----
    always_comb begin
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (do_write) begin
            mem_we_d    = sel_hit;
            mem_addr_d  = sel_ptr;
            mem_wdata_d = LOAD_DATA;
        end

        load_err_d = load_err_q || (accept && !do_write);

        // LAST loads RST_HOLD-1 so the core is released RST_HOLD cycles
        // after the final MEM_WE pulse.
        hold_cnt_d = hold_cnt_q;
        if (accept && LOAD_LAST)
            hold_cnt_d = HOLD_W'(RST_HOLD - 1);
        else if (state_q == S_HOLD && hold_cnt_q != '0)
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);

        cycle_cnt_d = cycle_cnt_q;
        if (state_q == S_RUN && cycle_cnt_q != '1)
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);

        done_d      = done_q || tohost_hit || timeout_hit;
        pass_d      = pass_q;
        result_d    = result_q;
        timed_out_d = timed_out_q;
        if (tohost_hit) begin
            result_d = RAM_DATAIN;
            pass_d   = (RAM_DATAIN == DATA_W'(PASS_CODE));
        end else if (timeout_hit) begin
            timed_out_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hold_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            load_err_q  <= 1'b0;
            result_q    <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hold_cnt_q  <= hold_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            load_err_q  <= load_err_d;
            result_q    <= result_d;
        end
    end

    assign MEM_WE      = mem_we_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WDATA   = mem_wdata_q;
    assign CYCLE_COUNT = cycle_cnt_q;
    assign DONE        = done_q;
    assign PASS        = pass_q;
    assign TIMED_OUT   = timed_out_q;
    assign LOAD_ERR    = load_err_q;
    assign RESULT      = result_q;

endmodule

// File: tb/tb_riscv_boot_sequencer.sv
// Bench for riscv_boot_sequencer (ADDR_W=2, NUM_MEM=2, SEL_W=2 so that an
// out-of-range select of 3 is representable). Memory writes are checked
// through a scoreboard queue; run outcomes come from a vector table.
module tb_riscv_boot_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        LOAD_VALID, LOAD_READY, LOAD_LAST;
    logic [31:0] LOAD_DATA;
    logic [1:0]  LOAD_SEL;
    logic [1:0]  MEM_WE;
    logic [1:0]  MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic        CORE_RESET_N;
    logic [31:0] RAM_ADDRESS, RAM_DATAIN;
    logic        RAM_WE;
    logic [31:0] TIMEOUT_LIMIT, CYCLE_COUNT, RESULT;
    logic        DONE, PASS, TIMED_OUT, LOAD_ERR;

    riscv_boot_sequencer #(
        .DATA_W(32), .ADDR_W(2), .NUM_MEM(2), .SEL_W(2),
        .RST_HOLD(4), .CNT_W(32), .TOHOST_ADDR(32'h0000_0FFC)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY), .LOAD_DATA(LOAD_DATA),
        .LOAD_SEL(LOAD_SEL), .LOAD_LAST(LOAD_LAST),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .CORE_RESET_N(CORE_RESET_N),
        .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATAIN(RAM_DATAIN), .RAM_WE(RAM_WE),
        .TIMEOUT_LIMIT(TIMEOUT_LIMIT), .CYCLE_COUNT(CYCLE_COUNT),
        .DONE(DONE), .PASS(PASS), .TIMED_OUT(TIMED_OUT), .LOAD_ERR(LOAD_ERR),
        .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  we;
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       name;
        int          inject;     // run cycle of the store, -1 = none
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] limit;
        logic        exp_pass;
        logic        exp_to;
        logic [31:0] exp_result;
        logic [31:0] exp_count;
    } vec_t;

    wr_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    logic [1:0] m_ptr [2];
    logic       m_full[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every MEM_WE pulse must match the oldest expected write.
    always @(negedge CLK) begin
        if (MEM_WE != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: MEM_WE=%b addr=%0d data=%0h expected no write",
                         MEM_WE, MEM_ADDR, MEM_WDATA);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("mem_we",    32'(MEM_WE),   32'(e.we));
                chk("mem_addr",  32'(MEM_ADDR), 32'(e.addr));
                chk("mem_wdata", MEM_WDATA,     e.data);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_we"},    32'(MEM_WE), 0);
        chk({tag, "_mem_addr"},  32'(MEM_ADDR), 0);
        chk({tag, "_mem_wdata"}, MEM_WDATA, 0);
        chk({tag, "_core_rst"},  32'(CORE_RESET_N), 0);
        chk({tag, "_cycles"},    CYCLE_COUNT, 0);
        chk({tag, "_done"},      32'(DONE), 0);
        chk({tag, "_pass"},      32'(PASS), 0);
        chk({tag, "_timed_out"}, 32'(TIMED_OUT), 0);
        chk({tag, "_load_err"},  32'(LOAD_ERR), 0);
        chk({tag, "_result"},    RESULT, 0);
        chk({tag, "_ready"},     32'(LOAD_READY), 1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("sb_drained", 32'(sb.size()), 0);
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i]  = 2'd0;
            m_full[i] = 1'b0;
        end
    endtask

    // Drive one accepted beat and predict its write.
    task automatic send_beat(input logic [1:0] sel, input logic [31:0] data, input logic last);
        int s;
        s = int'(sel);
        chk("ready_in_load", 32'(LOAD_READY), 1);
        LOAD_VALID = 1'b1;
        LOAD_SEL   = sel;
        LOAD_DATA  = data;
        LOAD_LAST  = last;
        if (s < 2) begin
            if (!m_full[s]) begin
                sb.push_back('{we: 2'(1 << s), addr: m_ptr[s], data: data});
                if (m_ptr[s] == 2'd3) m_full[s] = 1'b1;
                m_ptr[s] = m_ptr[s] + 2'd1;
            end
        end
        @(posedge CLK); #1;
        LOAD_VALID = 1'b0;
        LOAD_LAST  = 1'b0;
    endtask

    task automatic wait_release();
        int n = 0;
        while (CORE_RESET_N !== 1'b1 && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("release", 32'(CORE_RESET_N), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        do_reset();
        TIMEOUT_LIMIT = v.limit;
        send_beat(2'd0, 32'h0000_0013, 1'b1);
        wait_release();
        chk({v.name, "_cnt0"}, CYCLE_COUNT, 0);
        while (DONE !== 1'b1 && n < 200) begin
            if (v.inject >= 0 && CYCLE_COUNT == 32'(v.inject)) begin
                RAM_WE      = 1'b1;
                RAM_ADDRESS = v.addr;
                RAM_DATAIN  = v.data;
            end
            @(posedge CLK); #1;
            RAM_WE = 1'b0;
            n++;
        end
        chk({v.name, "_done"},      32'(DONE), 1);
        chk({v.name, "_pass"},      32'(PASS), 32'(v.exp_pass));
        chk({v.name, "_timed_out"}, 32'(TIMED_OUT), 32'(v.exp_to));
        chk({v.name, "_result"},    RESULT, v.exp_result);
        chk({v.name, "_count"},     CYCLE_COUNT, v.exp_count);
        chk({v.name, "_core_rst"},  32'(CORE_RESET_N), 0);
        chk({v.name, "_ready"},     32'(LOAD_READY), 0);
        repeat (3) @(posedge CLK);
        #1;
        chk({v.name, "_count_hold"}, CYCLE_COUNT, v.exp_count);
        chk({v.name, "_done_hold"},  32'(DONE), 1);
    endtask

    vec_t vecs[8];

    initial begin
        RESET = 1'b1; LOAD_VALID = 1'b0; LOAD_LAST = 1'b0; LOAD_SEL = 2'd0; LOAD_DATA = '0;
        RAM_WE = 1'b0; RAM_ADDRESS = '0; RAM_DATAIN = '0; TIMEOUT_LIMIT = '0;
        vecs[0] = '{"pass",       20, 32'hFFC, 32'd1, 32'd0,  1'b1, 1'b0, 32'd1, 32'd21};
        vecs[1] = '{"fail5",      20, 32'hFFC, 32'd5, 32'd0,  1'b0, 1'b0, 32'd5, 32'd21};
        vecs[2] = '{"timeout",    -1, 32'hFFC, 32'd0, 32'd10, 1'b0, 1'b1, 32'd0, 32'd10};
        vecs[3] = '{"tie_pass",    9, 32'hFFC, 32'd1, 32'd10, 1'b1, 1'b0, 32'd1, 32'd10};
        vecs[4] = '{"tie_fail",    9, 32'hFFC, 32'd7, 32'd10, 1'b0, 1'b0, 32'd7, 32'd10};
        vecs[5] = '{"wrong_addr",  3, 32'hFF8, 32'd1, 32'd12, 1'b0, 1'b1, 32'd0, 32'd12};
        vecs[6] = '{"first_cyc",   0, 32'hFFC, 32'd1, 32'd0,  1'b1, 1'b0, 32'd1, 32'd1};
        vecs[7] = '{"limit1",     -1, 32'hFFC, 32'd0, 32'd1,  1'b0, 1'b1, 32'd0, 32'd1};

        @(posedge CLK); #1;
        do_reset();
        chk_reset_vals("por");

        // Three ROM words; core released 4 cycles after the last write.
        send_beat(2'd0, 32'h0000_0013, 1'b0);
        send_beat(2'd0, 32'h0010_0093, 1'b0);
        send_beat(2'd0, 32'h0000_0063, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("hold_core_rst_%0d", k), 32'(CORE_RESET_N), (k == 4) ? 1 : 0);
            if (k == 1) chk("hold_ready", 32'(LOAD_READY), 0);
        end
        chk("release_cnt0", CYCLE_COUNT, 0);

        // Interleaved channels keep independent pointers.
        do_reset();
        send_beat(2'd0, 32'hA000_0000, 1'b0);
        send_beat(2'd1, 32'hB000_0000, 1'b0);
        send_beat(2'd0, 32'hA000_0001, 1'b0);
        send_beat(2'd1, 32'hB000_0001, 1'b1);
        @(posedge CLK); #1;
        chk("interleave_err", 32'(LOAD_ERR), 0);

        // Exhaustion: 4 writes fill channel 0, the 5th is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(2'd0, 32'hC0 + 32'(i), 1'b0);
        chk("full_err_before", 32'(LOAD_ERR), 0);
        send_beat(2'd0, 32'hC4, 1'b1);
        chk("full_err_after", 32'(LOAD_ERR), 1);
        chk("full_last_hold", 32'(LOAD_READY), 0);
        wait_release();
        chk("err_sticky_run", 32'(LOAD_ERR), 1);

        // Out-of-range select is dropped without consuming a pointer.
        do_reset();
        send_beat(2'd3, 32'hDEAD_BEEF, 1'b0);
        chk("sel3_err", 32'(LOAD_ERR), 1);
        send_beat(2'd1, 32'h0000_1111, 1'b1);

        // Run outcome table.
        foreach (vecs[i]) run_vec(vecs[i]);

        // No timeout when the limit is 0.
        do_reset();
        TIMEOUT_LIMIT = 32'd0;
        send_beat(2'd0, 32'h13, 1'b1);
        wait_release();
        repeat (1000) @(posedge CLK);
        #1;
        chk("nolimit_done", 32'(DONE), 0);
        chk("nolimit_count", CYCLE_COUNT, 1000);

        // Reset mid-load, then reload from address 0.
        do_reset();
        send_beat(2'd0, 32'h1, 1'b0);
        send_beat(2'd0, 32'h2, 1'b0);
        do_reset();
        chk_reset_vals("midload");
        send_beat(2'd0, 32'h3, 1'b1);

        // Reset mid-run, then reload from address 0.
        do_reset();
        send_beat(2'd1, 32'h4, 1'b0);
        send_beat(2'd0, 32'h5, 1'b1);
        wait_release();
        repeat (5) @(posedge CLK);
        #1;
        do_reset();
        chk_reset_vals("midrun");
        send_beat(2'd1, 32'h6, 1'b1);
        wait_release();
        chk("reload_cnt0", CYCLE_COUNT, 0);
        chk("sb_final", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
